cpu_bus_timer_slave: RTL and testbench

//  Memory-mapped timer peripheral on the DUT side of the CPU memory bus.

---
 rtl/cpu_bus_timer_slave.sv | 166 ++++++++++++++++
 tb/tb_cpu_bus_timer_slave.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_timer_slave.sv
// cpu_bus_timer_slave
//
// Memory-mapped timer peripheral sitting on the CPU memory bus. It claims an
// 8-word window at BASE_ADDR, accepts byte-strobed writes, returns registered
// read data one cycle after the access, and raises a level interrupt when the
// prescaled 32-bit up-counter matches the compare register.
//
// Register window (word offset within the window):
//   0 CTRL   RW  [0] EN, [1] IE, [2] AR (auto-reload to 0 on match)
//   1 PRESC  RW  [15:0] prescale divider (tick every PRESC+1 enabled cycles)
//   2 COUNT  RW  32-bit counter
//   3 CMP    RW  32-bit compare value
//   4 STATUS     [0] MATCH, write-1-to-clear
//   5 ID     RO  ID_VALUE
//   6-7          read 0, writes ignored
//
// Ports:
//   clock     in   single clock, rising edge
//   reset     in   asynchronous, active-low reset
//   addr_out  in   CPU word address (MEMORY_BUS_WIDTH-2 bits)
//   data_out  in   CPU write data
//   wb_out    in   byte write strobes, bit i covers data bits [8i+7:8i]; 0 = read
//   data_in   out  registered read data; 0 whenever the window is not addressed
//   irq       out  registered MATCH & IE, level, active-high

module cpu_bus_timer_slave #(
  parameter int          MEMORY_BUS_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0100,
  parameter logic [31:0] ID_VALUE         = 32'h7131_0001
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-3:0] addr_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] data_out,
  input  logic [3:0]                  wb_out,
  output logic [MEMORY_BUS_WIDTH-1:0] data_in,
  output logic                        irq
);

  localparam int DW = MEMORY_BUS_WIDTH;
  localparam int AW = MEMORY_BUS_WIDTH - 2;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_ID     = 3'd5;

  logic          ctrl_en;
  logic          ctrl_ie;
  logic          ctrl_ar;
  logic [15:0]   presc;
  logic [15:0]   pcnt;
  logic [DW-1:0] count;
  logic [DW-1:0] cmp;
  logic          match;

  logic          sel;
  logic [2:0]    off;
  logic          wr;
  logic [DW-1:0] byte_mask;
  logic          tick;
  logic          match_hit;
  logic          w1c;
  logic [DW-1:0] rd_mux;

  // Window decode: the low three word-address bits pick the register, the rest
  // must equal the base address.
  assign sel = (addr_out[AW-1:3] == BASE_ADDR[AW-1:3]);
  assign off = addr_out[2:0];
  assign wr  = sel && (wb_out != 4'b0000);

  assign byte_mask = {{8{wb_out[3]}}, {8{wb_out[2]}}, {8{wb_out[1]}}, {8{wb_out[0]}}};

  // A tick is issued on the cycle the prescale counter reaches the divider, so
  // PRESC=0 ticks every enabled cycle. Compare uses pre-edge register values.
  assign tick      = ctrl_en && (pcnt == presc);
  assign match_hit = tick && (count == cmp);
  assign w1c       = wr && (off == OFF_STATUS) && wb_out[0] && data_out[0];

  // Read mux; unimplemented bits are tied to 0.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux = {{(DW-3){1'b0}}, ctrl_ar, ctrl_ie, ctrl_en};
      OFF_PRESC:  rd_mux = {{(DW-16){1'b0}}, presc};
      OFF_COUNT:  rd_mux = count;
      OFF_CMP:    rd_mux = cmp;
      OFF_STATUS: rd_mux = {{(DW-1){1'b0}}, match};
      OFF_ID:     rd_mux = ID_VALUE;
      default:    rd_mux = '0;
    endcase
  end

  // Control register; only byte lane 0 carries implemented bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      ctrl_ar <= 1'b0;
    end else if (wr && (off == OFF_CTRL) && wb_out[0]) begin
      ctrl_en <= data_out[0];
      ctrl_ie <= data_out[1];
      ctrl_ar <= data_out[2];
    end
  end

  // Divider and compare registers, byte-lane writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      cmp   <= '0;
    end else begin
      if (wr && (off == OFF_PRESC))
        presc <= (presc & ~byte_mask[15:0]) | (data_out[15:0] & byte_mask[15:0]);
      if (wr && (off == OFF_CMP))
        cmp <= (cmp & ~byte_mask) | (data_out & byte_mask);
    end
  end

  // Prescale counter restarts whenever the timer is disabled, on every tick,
  // and on any PRESC write so a new divider takes effect from a clean phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      pcnt <= '0;
    else if ((wr && (off == OFF_PRESC)) || !ctrl_en || tick)
      pcnt <= '0;
    else
      pcnt <= pcnt + 16'd1;
  end

  // Counter: a CPU write wins outright over the tick update; unwritten lanes
  // keep their old value without incrementing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (wr && (off == OFF_COUNT))
      count <= (count & ~byte_mask) | (data_out & byte_mask);
    else if (tick)
      count <= (match_hit && ctrl_ar) ? '0 : count + 1'b1;
  end

  // MATCH flag: a new match beats a simultaneous write-1-to-clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      match <= 1'b0;
    else if (match_hit)
      match <= 1'b1;
    else if (w1c)
      match <= 1'b0;
  end

  // Registered read data and interrupt. irq is built only from flop outputs so
  // it cannot glitch, and lags MATCH/IE by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_in <= '0;
      irq     <= 1'b0;
    end else begin
      data_in <= sel ? rd_mux : '0;
      irq     <= match && ctrl_ie;
    end
  end

endmodule

// File: tb/tb_cpu_bus_timer_slave.sv
// tb_cpu_bus_timer_slave
//
// Self-checking bench for cpu_bus_timer_slave: directed scenarios followed by
// randomized bus traffic, compared every cycle against a behavioural model of
// the register file, prescaler and counter.

module tb_cpu_bus_timer_slave;

  localparam logic [29:0] BASE = 30'h0000_0100;
  localparam logic [31:0] ID   = 32'h7131_0001;

  logic        clock;
  logic        reset;
  logic [29:0] addr_out;
  logic [31:0] data_out;
  logic [3:0]  wb_out;
  logic [31:0] data_in;
  logic        irq;

  int tests;
  int failures;

  // Reference model state (values expected after the most recent edge).
  bit          m_en, m_ie, m_ar, m_match, m_irq;
  logic [15:0] m_presc, m_pcnt;
  logic [31:0] m_count, m_cmp, m_data_in;

  cpu_bus_timer_slave #(
    .MEMORY_BUS_WIDTH(32),
    .BASE_ADDR(32'h0000_0100),
    .ID_VALUE(32'h7131_0001)
  ) dut (
    .clock(clock),
    .reset(reset),
    .addr_out(addr_out),
    .data_out(data_out),
    .wb_out(wb_out),
    .data_in(data_in),
    .irq(irq)
  );

  // 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_ar = 0; m_match = 0; m_irq = 0;
    m_presc = '0; m_pcnt = '0; m_count = '0; m_cmp = '0; m_data_in = '0;
  endtask

  // Advance the model by one rising edge given the bus inputs of that cycle.
  task automatic model_edge(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
    bit          sel, wr, tick, hit;
    logic [2:0]  off;
    logic [31:0] mask, rd;
    sel  = (a >> 3) == (BASE >> 3);
    off  = a[2:0];
    wr   = sel && (w != 4'b0);
    mask = '0;
    for (int b = 0; b < 4; b++)
      if (w[b]) mask = mask | (32'hFF << (8 * b));
    case (off)
      3'd0:    rd = {29'd0, m_ar, m_ie, m_en};
      3'd1:    rd = {16'd0, m_presc};
      3'd2:    rd = m_count;
      3'd3:    rd = m_cmp;
      3'd4:    rd = {31'd0, m_match};
      3'd5:    rd = ID;
      default: rd = '0;
    endcase
    m_data_in = sel ? rd : 32'd0;
    m_irq     = m_match && m_ie;
    tick = m_en && (m_pcnt == m_presc);
    hit  = tick && (m_count == m_cmp);
    if ((wr && off == 3'd1) || !m_en || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    if (wr && off == 3'd2) m_count = (m_count & ~mask) | (d & mask);
    else if (tick) m_count = (hit && m_ar) ? 32'd0 : m_count + 1;
    if (hit) m_match = 1;
    else if (wr && off == 3'd4 && w[0] && d[0]) m_match = 0;
    if (wr && off == 3'd0 && w[0]) begin
      m_en = d[0]; m_ie = d[1]; m_ar = d[2];
    end
    if (wr && off == 3'd1) m_presc = (m_presc & ~mask[15:0]) | (d[15:0] & mask[15:0]);
    if (wr && off == 3'd3) m_cmp = (m_cmp & ~mask) | (d & mask);
  endtask

  // One bus cycle: drive on the falling edge, check just after the rising edge.
  task automatic apply_stimulus(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clock);
    addr_out = a; data_out = d; wb_out = w;
    model_edge(a, d, w);
    @(posedge clock);
    #1;
    check_output("data_in", data_in, m_data_in);
    check_output("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  // Asynchronous reset pulse asserted mid-cycle with an access in flight.
  task automatic do_reset();
    @(negedge clock);
    addr_out = BASE + 30'd5; data_out = $urandom; wb_out = 4'hF;
    #2 reset = 1'b0;
    #1;
    check_output("reset data_in", data_in, 32'd0);
    check_output("reset irq", {31'd0, irq}, 32'd0);
    model_reset();
    @(negedge clock);
    addr_out = '0; data_out = '0; wb_out = 4'h0;
    reset = 1'b1;
    model_edge(addr_out, data_out, wb_out);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    logic [2:0]  off;
    tests = 0; failures = 0;
    reset = 1'b1; addr_out = '0; data_out = '0; wb_out = '0;
    model_reset();

    // 1: reset with stimulus active, then ID read.
    do_reset();
    apply_stimulus(BASE + 30'd5, 32'd0, 4'h0);
    check_output("id read", data_in, 32'h7131_0001);

    // 2: partial byte-lane write to COUNT.
    apply_stimulus(BASE + 30'd2, 32'hAABB_CCDD, 4'b0101);
    apply_stimulus(BASE + 30'd2, 32'd0, 4'h0);
    check_output("count lanes", data_in, 32'h00BB_00DD);

    // 3: PRESC=3, CMP=2, EN+IE; tick every 4 cycles, irq after the 3rd tick.
    apply_stimulus(BASE + 30'd1, 32'd3, 4'hF);
    apply_stimulus(BASE + 30'd3, 32'd2, 4'hF);
    apply_stimulus(BASE + 30'd2, 32'd0, 4'hF);
    apply_stimulus(BASE + 30'd0, 32'd3, 4'h1);
    for (int k = 1; k <= 13; k++) begin
      apply_stimulus(BASE + 30'd2, 32'd0, 4'h0);
      check_output("presc count", data_in, 32'((k - 1) / 4));
      if (k == 12) check_output("irq before", {31'd0, irq}, 32'd0);
      if (k == 13) check_output("irq after", {31'd0, irq}, 32'd1);
    end

    // 4: auto-reload, PRESC=0, CMP=5.
    apply_stimulus(BASE + 30'd0, 32'd0, 4'h1);
    apply_stimulus(BASE + 30'd4, 32'd1, 4'h1);
    apply_stimulus(BASE + 30'd1, 32'd0, 4'hF);
    apply_stimulus(BASE + 30'd3, 32'd5, 4'hF);
    apply_stimulus(BASE + 30'd2, 32'd0, 4'hF);
    apply_stimulus(BASE + 30'd0, 32'd7, 4'h1);
    for (int k = 1; k <= 13; k++) begin
      apply_stimulus(BASE + 30'd2, 32'd0, 4'h0);
      check_output("reload count", data_in, 32'((k - 1) % 6));
      if (k == 6) check_output("reload irq low", {31'd0, irq}, 32'd0);
      if (k == 7) check_output("reload irq high", {31'd0, irq}, 32'd1);
    end

    // 5: W1C on the same edge as a match; match wins, later W1C drops irq.
    apply_stimulus(BASE + 30'd0, 32'd0, 4'h1);
    apply_stimulus(BASE + 30'd4, 32'd1, 4'h1);
    apply_stimulus(BASE + 30'd2, 32'd0, 4'hF);
    apply_stimulus(BASE + 30'd0, 32'd7, 4'h1);
    for (int k = 1; k <= 5; k++) apply_stimulus(BASE + 30'd2, 32'd0, 4'h0);
    apply_stimulus(BASE + 30'd4, 32'd1, 4'h1);
    apply_stimulus(BASE + 30'd4, 32'd0, 4'h0);
    check_output("match kept", data_in, 32'd1);
    check_output("irq kept", {31'd0, irq}, 32'd1);
    apply_stimulus(BASE + 30'd0, 32'd2, 4'h1);
    apply_stimulus(BASE + 30'd4, 32'd1, 4'h1);
    check_output("irq pre clear", {31'd0, irq}, 32'd1);
    apply_stimulus(BASE + 30'd4, 32'd0, 4'h0);
    check_output("irq cleared", {31'd0, irq}, 32'd0);
    check_output("match cleared", data_in, 32'd0);

    // 6: writes just outside the window change nothing and read 0.
    for (int j = 0; j < 8; j++) begin
      apply_stimulus(BASE + 30'd8 + 30'(j), $urandom, 4'hF);
      check_output("outside read", data_in, 32'd0);
    end
    for (int j = 0; j < 5; j++) apply_stimulus(BASE + 30'(j), 32'd0, 4'h0);

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      off = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 30'($urandom);
      else a = BASE + 30'(off);
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      d = $urandom;
      if (off == 3'd1) d[15:0] = 16'($urandom_range(0, 3));
      if (off == 3'd2 || off == 3'd3) d = 32'($urandom_range(0, 20));
      if (off == 3'd0) d[0] = ($urandom_range(0, 3) != 0);
      apply_stimulus(a, d, w);
      if (i == 200) do_reset();
    end

    // Reset mid-operation loses counter and flags.
    do_reset();
    apply_stimulus(BASE + 30'd2, 32'd0, 4'h0);
    check_output("count after reset", data_in, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
